// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch (IF), load/store (LS) and loader (LD); grant is combinational,
// read data returns one cycle later; a refused requester holds its request until granted.
module mem_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int LD_BURST = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] OWN_IF = 2'd0;
  localparam logic [1:0] OWN_LS = 2'd1;
  localparam logic [1:0] OWN_LD = 2'd2;

  logic          r_ptr;      // 1 = LS was the last CPU-side owner
  logic [3:0]    r_burst;
  logic          r_rd_vld;
  logic [1:0]    r_rd_own;
  logic [DW-1:0] r_rdata;

  logic w_cpu_req;
  logic w_ld_cap;
  logic w_ld_win;
  logic w_if_win;
  logic w_ls_win;

  assign w_cpu_req = if_req | ls_req;
  assign w_ld_cap  = (r_burst == 4'(LD_BURST));
  assign w_ld_win  = ld_req & ~(w_ld_cap & w_cpu_req);
  // With both CPU requesters active, the one not served last goes first.
  assign w_if_win  = ~w_ld_win & if_req & (~ls_req | r_ptr);
  assign w_ls_win  = ~w_ld_win & ls_req & ~w_if_win;

  assign if_gnt = w_if_win & reset_n;
  assign ls_gnt = w_ls_win & reset_n;
  assign ld_gnt = w_ld_win & reset_n;

  assign mem_en    = if_gnt | ls_gnt | ld_gnt;
  assign mem_we    = (ls_gnt & ls_we) | (ld_gnt & ld_we);
  assign mem_addr  = ld_gnt ? ld_addr  : ls_gnt ? ls_addr : if_gnt ? if_addr : '0;
  assign mem_wdata = ld_gnt ? ld_wdata : ls_gnt ? ls_wdata : '0;

  assign if_rvalid = r_rd_vld & (r_rd_own == OWN_IF);
  assign ls_rvalid = r_rd_vld & (r_rd_own == OWN_LS);
  assign ld_rvalid = r_rd_vld & (r_rd_own == OWN_LD);
  assign rdata     = r_rd_vld ? mem_rdata : r_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr    <= 1'b1;
      r_burst  <= '0;
      r_rd_vld <= 1'b0;
      r_rd_own <= OWN_IF;
      r_rdata  <= '0;
    end else begin
      if (if_gnt | ls_gnt)
        r_ptr <= ls_gnt;
      if (!ld_req || if_gnt || ls_gnt)
        r_burst <= '0;
      else if (ld_gnt && !w_ld_cap)
        r_burst <= r_burst + 4'd1;
      r_rd_vld <= mem_en & ~mem_we;
      r_rd_own <= ld_gnt ? OWN_LD : ls_gnt ? OWN_LS : OWN_IF;
      if (r_rd_vld)
        r_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 256x32 synchronous memory.
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic          ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ld_req, ld_we, ld_gnt, ld_rvalid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LD_BURST(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory: unwritten words read back a fixed pattern, word 3 holds DEADBEEF.
  logic [DW-1:0] mem_arr [256];
  logic [255:0]  wr_vld = '0;
  logic [DW-1:0] mem_q  = '0;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (a == 8'd3) ? 32'hDEADBEEF : (32'hA500_0000 | {24'h0, a});
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_arr[mem_addr] <= mem_wdata;
        wr_vld[mem_addr]  <= 1'b1;
      end else begin
        mem_q <= wr_vld[mem_addr] ? mem_arr[mem_addr] : init_word(mem_addr);
      end
    end
  end
  assign mem_rdata = mem_q;

  // A requester must not drop req before it has been granted.
  logic p_if = 1'b0, p_ls = 1'b0, p_ld = 1'b0, proto_bad = 1'b0;
  always @(posedge clk) begin
    assert (!((p_if && !if_req) || (p_ls && !ls_req) || (p_ld && !ld_req)))
      else proto_bad <= 1'b1;
    p_if <= reset_n & if_req & ~if_gnt;
    p_ls <= reset_n & ls_req & ~ls_gnt;
    p_ld <= reset_n & ld_req & ~ld_gnt;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_gnt(input string tag, input logic e_if, input logic e_ls, input logic e_ld);
    check(tag, {61'd0, if_gnt, ls_gnt, ld_gnt}, {61'd0, e_if, e_ls, e_ld});
  endtask

  task automatic check_rv(input string tag, input logic e_if, input logic e_ls, input logic e_ld);
    check(tag, {61'd0, if_rvalid, ls_rvalid, ld_rvalid}, {61'd0, e_if, e_ls, e_ld});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic e_if;
    reset_n = 1'b0;
    if_req = 1'b1; if_addr = 8'd3;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'd7; ls_wdata = '0;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'd0; ld_wdata = '0;

    // Reset with every requester active
    tick();
    check_gnt("rst_gnt", 0, 0, 0);
    check("rst_mem_en", mem_en, 0);
    check_rv("rst_rvalid", 0, 0, 0);
    check("rst_rdata", rdata, 0);
    ld_req = 1'b0;
    tick();
    reset_n = 1'b1;

    // IF/LS round-robin, last cycle IF alone
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin
        e_if = ((k - 1) % 2 == 0);
        check_rv("rr_rvalid", e_if, !e_if, 0);
        check("rr_rdata", rdata, e_if ? 32'hDEADBEEF : 32'hA500_0007);
      end
      if (k == 6) ls_req = 1'b0;
      #1;
      e_if = (k % 2 == 0);
      check_gnt("rr_gnt", e_if, !e_if, 0);
      check("rr_addr", mem_addr, e_if ? 8'd3 : 8'd7);
      tick();
    end
    if_req = 1'b0;
    check_rv("rr_last_rvalid", 1, 0, 0);
    check("rr_last_rdata", rdata, 32'hDEADBEEF);
    #1;
    check("idle_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    tick();
    check_rv("idle_rvalid", 0, 0, 0);

    // Store then read back
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h10; ls_wdata = 32'h1234_5678;
    #1;
    check_gnt("st_gnt", 0, 1, 0);
    check("st_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 8'h10, 32'h1234_5678});
    tick();
    ls_req = 1'b0; ls_we = 1'b0;
    check_rv("st_no_rvalid", 0, 0, 0);
    check("rdata_hold", rdata, 32'hDEADBEEF);
    if_req = 1'b1; if_addr = 8'h10;
    #1;
    check_gnt("rb_gnt", 1, 0, 0);
    check("rb_we", mem_we, 0);
    tick();
    check_rv("rb_rvalid", 1, 0, 0);
    check("rb_rdata", rdata, 32'h1234_5678);
    if_addr = 8'hFF;
    #1;
    check("a255_addr", mem_addr, 8'hFF);
    tick();
    if_req = 1'b0;
    check_rv("a255_rvalid", 1, 0, 0);
    check("a255_rdata", rdata, 32'hA500_00FF);

    // Loader burst cap against a waiting fetch
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h20;
    if_req = 1'b1; if_addr = 8'h21;
    for (int k = 0; k < 10; k++) begin
      e_if = (k % 5 == 4);
      #1;
      check_gnt("burst_gnt", e_if, 0, !e_if);
      tick();
      check_rv("burst_rvalid", e_if, 0, !e_if);
      check("burst_rdata", rdata, e_if ? 32'hA500_0021 : 32'hA500_0020);
    end
    if_req = 1'b0;
    #1;
    check_gnt("burst_tail_gnt", 0, 0, 1);
    tick();

    // Loader alone: writes every cycle, never forced off
    ld_we = 1'b1;
    for (int k = 0; k < 20; k++) begin
      ld_addr = 8'h40 + 8'(k);
      ld_wdata = 32'hC0DE_0000 + 32'(k);
      #1;
      check_gnt("ld_alone_gnt", 0, 0, 1);
      tick();
    end
    check_rv("ld_write_no_rvalid", 0, 0, 0);

    // Reset during a granted fetch
    ld_we = 1'b0; ld_addr = 8'h41;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_gnt("pre_rst_ld_gnt", 0, 0, 1);
      tick();
    end
    check_rv("ld_rvalid", 0, 0, 1);
    check("ld_rdata", rdata, 32'hC0DE_0001);
    if_req = 1'b1; if_addr = 8'h42;
    #1;
    check_gnt("forced_if_gnt", 1, 0, 0);
    #1;
    reset_n = 1'b0;
    #1;
    check_gnt("mid_rst_gnt", 0, 0, 0);
    tick();
    check_rv("mid_rst_rvalid", 0, 0, 0);
    check("mid_rst_rdata", rdata, 0);
    ls_req = 1'b1;
    tick();
    reset_n = 1'b1;
    check_rv("post_rst_rvalid", 0, 0, 0);
    // Cleared counter lets LD in four times; cleared pointer gives the tie to IF.
    for (int k = 0; k < 5; k++) begin
      e_if = (k == 4);
      #1;
      check_gnt("post_rst_gnt", e_if, 0, !e_if);
      tick();
    end
    if_req = 1'b0;
    #1;
    check_gnt("post_rst_ld_again", 0, 0, 1);
    tick();
    ld_req = 1'b0;
    #1;
    check_gnt("post_rst_ls", 0, 1, 0);
    tick();
    ls_req = 1'b0;
    tick();
    check("protocol", proto_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the processor's single-port 256x32 word memory among three requesters: instruction fetch (IF), data load/store (LS) and the program loader (LD, a host/UART image loader).
- Grants at most one access per cycle and routes read data back to the owner one cycle later.
- Sits between the fetch/execute stages and the memory array, and is the only block that drives the memory control pins.

Parameters:
- AW, 8, word address width (256 words).
- DW, 32, data width.
- LD_BURST, 4, maximum consecutive LD grants before a pending CPU request (IF or LS) must be served; range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- ls_req  in  1  load/store request.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  AW  load/store address.
- ls_wdata  in  DW  store data.
- ls_gnt  out  1  load/store request accepted.
- ls_rvalid  out  1  load data valid.
- ld_req  in  1  loader request.
- ld_we  in  1  loader write enable.
- ld_addr  in  AW  loader address.
- ld_wdata  in  DW  loader write data.
- ld_gnt  out  1  loader request accepted.
- ld_rvalid  out  1  loader read data valid.
- rdata  out  DW  shared read data, qualified by the *_rvalid strobes.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid one cycle after a read access.

Behaviour:
- Handshake:
  - A requester holds req, addr, we and wdata stable until it sees gnt.
  - gnt is a combinational, single-cycle acceptance; at most one gnt is high per cycle.
  - A granted request drives mem_* in the same cycle.
- Priority:
  - LD beats IF/LS, except when the LD burst counter equals LD_BURST and IF or LS is requesting. In that case the CPU side wins that cycle.
- Burst counter:
  - Increments on each LD grant.
  - Clears on any IF/LS grant and on any cycle in which ld_req is low.
  - Saturates at LD_BURST.
- IF vs LS:
  - Round-robin with a 1-bit last-owner pointer, updated only on an IF/LS grant.
  - If both request, the one not granted last wins.
  - If only one requests, it wins regardless of the pointer.
- Memory outputs:
  - mem_en = any gnt.
  - mem_we = granted requester's we (IF always reads).
  - mem_addr and mem_wdata are muxed from the granted requester.
  - When idle: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Read return:
  - A 2-bit owner register plus a valid flag records each granted read.
  - Next cycle, exactly one of if/ls/ld_rvalid pulses for one cycle, with rdata = mem_rdata.
  - Writes produce no rvalid.
  - Back-to-back reads are supported: one grant per cycle gives one rvalid per cycle, 1-cycle latency, full throughput.
- Reset:
  - Asynchronous. Clears the pointer (last owner = LS, so IF wins the first tie), the burst counter and the read-pending flag.
  - All *_rvalid = 0 and rdata = 0 during and after reset until the first read returns.
  - Gnt outputs are 0 while reset_n is low.
  - A read granted in the cycle reset asserts produces no rvalid.
- Boundaries:
  - Address 255 is passed unmodified; there is no wrap logic here.
  - A req deasserted without a gnt is a protocol violation; the bench flags it with an assertion.
  - rdata holds its last value when no rvalid is high.

Test Plan:
- Reset: hold reset_n=0 with all reqs high -> all gnt/rvalid=0, mem_en=0. Release -> first tie between IF and LS goes to IF.
- IF/LS round-robin: if_req and ls_req held high for 6 cycles, ls_we=0 -> grants alternate IF,LS,IF,LS,IF,LS. Rvalid alternates one cycle later, and rdata matches the preloaded words (mem[3]=0xDEADBEEF returned to the correct owner).
- Store path: ls_req, ls_we=1, ls_addr=0x10, ls_wdata=0x12345678 -> ls_gnt, mem_we=1, mem_addr=0x10 the same cycle, no ls_rvalid. A later IF read of 0x10 returns 0x12345678.
- LD burst cap: ld_req and if_req high continuously, LD_BURST=4 -> grant pattern LD,LD,LD,LD,IF,LD,LD,LD,LD,IF.
- Loader alone: ld_req high for 20 cycles, no CPU requests -> 20 consecutive LD grants with no forced gap.
- Reset mid-read: grant an IF read and assert reset_n=0 before the next edge -> no if_rvalid appears, and the pointer and burst counter read back as their reset values.
